// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: grants the single 8-bit external RAM port to the
// instruction-fetch path or the data path, one access at a time.
//
// Each access runs IDLE -> SETUP -> STROBE x WAIT_CYC -> DONE -> IDLE.
// All outputs are registered from the next-state decode.
//
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   fetch_req     fetch read request, held until fetch_done
//   fetch_addr    fetch address (PC)
//   fetch_rdata   last byte fetched
//   fetch_done    one-cycle completion pulse for fetch
//   data_req      data request, held until data_done
//   data_we       1 = write, 0 = read
//   data_addr     data address (MAR)
//   data_wdata    write byte (MDR)
//   data_rdata    last byte read by the data port
//   data_done     one-cycle completion pulse for data
//   addr_ram      RAM address bus
//   ram_dout      byte driven toward dataram
//   ram_oe        top level drives dataram from ram_dout when 1
//   ram_din       sampled dataram value
//   wram, rram    active-low write / read strobes
//   busy          1 whenever not IDLE
//
// Parameter WAIT_CYC (1..15): strobe-active cycles per access.
// Macro RAM_ARB_ROUND_ROBIN_EN: round-robin tie break.
// Without it fetch always wins a tie.
module ram_port_arbiter #(
  parameter int WAIT_CYC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fetch_req,
  input  logic [7:0] fetch_addr,
  output logic [7:0] fetch_rdata,
  output logic       fetch_done,
  input  logic       data_req,
  input  logic       data_we,
  input  logic [7:0] data_addr,
  input  logic [7:0] data_wdata,
  output logic [7:0] data_rdata,
  output logic       data_done,
  output logic [7:0] addr_ram,
  output logic [7:0] ram_dout,
  output logic       ram_oe,
  input  logic [7:0] ram_din,
  output logic       wram,
  output logic       rram,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_DONE
  } state_t;

  localparam logic [3:0] LP_CNT_INIT =
    4'(WAIT_CYC - 1);

  state_t     r_state;
  state_t     w_nstate;

  logic [3:0] r_cnt;
  // Owner of the current access; 1 = data.
  logic       r_last_grant;
  logic       r_we;
  logic [7:0] r_addr;
  logic [7:0] r_wdata;
  logic [7:0] r_frdata;
  logic [7:0] r_drdata;
  logic       r_oe;
  logic       r_wram;
  logic       r_rram;
  logic       r_fdone;
  logic       r_ddone;
  logic       r_busy;

  logic       w_any;
  logic       w_tie_win;
  logic       w_win;
  logic       w_grant;
  logic       w_last;
  logic       w_we_nxt;
  logic       w_oe;
  logic       w_wram;
  logic       w_rram;
  logic       w_fdone;
  logic       w_ddone;
  logic       w_busy;

  assign w_any = fetch_req | data_req;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  // Tie goes to whoever lost last time.
  assign w_tie_win = ~r_last_grant;
`else
  assign w_tie_win = 1'b0;
`endif

  assign w_win = (fetch_req & data_req)
               ? w_tie_win : data_req;

  assign w_grant = (r_state == S_IDLE) & w_any;

  assign w_last = (r_state == S_STROBE)
                & (r_cnt == 4'd0);

  // we of the access the next cycle belongs to.
  assign w_we_nxt = w_grant ? (w_win & data_we)
                            : r_we;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nstate;
    end
  end

  always_comb begin
    w_nstate = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_nstate = S_SETUP;
        end
      end
      S_SETUP: begin
        w_nstate = S_STROBE;
      end
      S_STROBE: begin
        if (w_last) begin
          w_nstate = S_DONE;
        end
      end
      S_DONE: begin
        w_nstate = S_IDLE;
      end
      default: begin
        w_nstate = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_oe    = 1'b0;
    w_wram  = 1'b1;
    w_rram  = 1'b1;
    w_fdone = 1'b0;
    w_ddone = 1'b0;
    w_busy  = 1'b1;
    unique case (w_nstate)
      S_IDLE: begin
        w_busy = 1'b0;
      end
      S_SETUP: begin
        w_oe = w_we_nxt;
      end
      S_STROBE: begin
        w_oe   = w_we_nxt;
        w_wram = ~w_we_nxt;
        w_rram = w_we_nxt;
      end
      S_DONE: begin
        w_fdone = ~r_last_grant;
        w_ddone = r_last_grant;
      end
      default: begin
        w_busy = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt        <= 4'd0;
      r_last_grant <= 1'b1;
      r_we         <= 1'b0;
      r_addr       <= 8'h00;
      r_wdata      <= 8'h00;
      r_frdata     <= 8'h00;
      r_drdata     <= 8'h00;
      r_oe         <= 1'b0;
      r_wram       <= 1'b1;
      r_rram       <= 1'b1;
      r_fdone      <= 1'b0;
      r_ddone      <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      if (w_grant) begin
        r_last_grant <= w_win;
        r_we         <= w_we_nxt;
        r_addr       <= w_win ? data_addr
                              : fetch_addr;
        r_wdata      <= w_win ? data_wdata
                              : 8'h00;
      end
      if (r_state == S_SETUP) begin
        r_cnt <= LP_CNT_INIT;
      end else if (r_state == S_STROBE) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_last & ~r_we) begin
        if (r_last_grant) begin
          r_drdata <= ram_din;
        end else begin
          r_frdata <= ram_din;
        end
      end
      r_oe    <= w_oe;
      r_wram  <= w_wram;
      r_rram  <= w_rram;
      r_fdone <= w_fdone;
      r_ddone <= w_ddone;
      r_busy  <= w_busy;
    end
  end

  assign addr_ram    = r_addr;
  assign ram_dout    = r_wdata;
  assign ram_oe      = r_oe;
  assign wram        = r_wram;
  assign rram        = r_rram;
  assign fetch_done  = r_fdone;
  assign data_done   = r_ddone;
  assign fetch_rdata = r_frdata;
  assign data_rdata  = r_drdata;
  assign busy        = r_busy;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: bench for ram_port_arbiter,
// two instances (WAIT_CYC 1 and 3) against a timeline model.
module tb_ram_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       fetch_req;
  logic       data_req;
  logic       data_we;
  logic [7:0] fetch_addr;
  logic [7:0] data_addr;
  logic [7:0] data_wdata;
  logic [7:0] ram_din;

  wire [1:0][7:0] addr;
  wire [1:0][7:0] dout;
  wire [1:0][7:0] frd;
  wire [1:0][7:0] drd;
  wire [1:0]      oe;
  wire [1:0]      wr;
  wire [1:0]      rd;
  wire [1:0]      fd;
  wire [1:0]      dd;
  wire [1:0]      bs;

  ram_port_arbiter #(.WAIT_CYC(1)) u_w1 (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req),
    .fetch_addr(fetch_addr),
    .fetch_rdata(frd[0]),
    .fetch_done(fd[0]),
    .data_req(data_req),
    .data_we(data_we),
    .data_addr(data_addr),
    .data_wdata(data_wdata),
    .data_rdata(drd[0]),
    .data_done(dd[0]),
    .addr_ram(addr[0]),
    .ram_dout(dout[0]),
    .ram_oe(oe[0]),
    .ram_din(ram_din),
    .wram(wr[0]),
    .rram(rd[0]),
    .busy(bs[0])
  );

  ram_port_arbiter #(.WAIT_CYC(3)) u_w3 (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req),
    .fetch_addr(fetch_addr),
    .fetch_rdata(frd[1]),
    .fetch_done(fd[1]),
    .data_req(data_req),
    .data_we(data_we),
    .data_addr(data_addr),
    .data_wdata(data_wdata),
    .data_rdata(drd[1]),
    .data_done(dd[1]),
    .addr_ram(addr[1]),
    .ram_dout(dout[1]),
    .ram_oe(oe[1]),
    .ram_din(ram_din),
    .wram(wr[1]),
    .rram(rd[1]),
    .busy(bs[1])
  );

  int checks = 0;
  int errors = 0;

  task automatic check(string nm, int i,
                       logic [7:0] act,
                       logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %h want %h",
               nm, i, act, exp);
    end
  endtask

  function automatic int wc(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // Model: an access is a timeline measured in cycles
  // since grant (1 = setup, 2..1+W strobe, 2+W done).
  bit         m_busy  [2];
  int         m_d     [2];
  bit         m_win   [2];
  bit         m_we    [2];
  bit         m_last  [2];
  bit         m_fresh [2];
  logic [7:0] m_a     [2];
  logic [7:0] m_wd    [2];
  logic [7:0] m_frd   [2];
  logic [7:0] m_drd   [2];

  task automatic model_step(int i);
    int w;
    bit tw;
    w = wc(i);
    if (!rst) begin
      m_busy[i]  = 0;
      m_d[i]     = 0;
      m_we[i]    = 0;
      m_last[i]  = 1;
      m_fresh[i] = 1;
      m_a[i]     = 8'h00;
      m_wd[i]    = 8'h00;
      m_frd[i]   = 8'h00;
      m_drd[i]   = 8'h00;
    end else if (!m_busy[i]) begin
      if (fetch_req || data_req) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
        tw = !m_last[i];
`else
        tw = 0;
`endif
        m_win[i] = (fetch_req && data_req)
                 ? tw : data_req;
        m_a[i]  = m_win[i] ? data_addr
                           : fetch_addr;
        m_we[i] = m_win[i] && data_we;
        m_wd[i] = data_wdata;
        m_last[i]  = m_win[i];
        m_fresh[i] = 0;
        m_busy[i]  = 1;
        m_d[i]     = 1;
      end
    end else begin
      if (m_d[i] == 1 + w && !m_we[i]) begin
        if (m_win[i]) m_drd[i] = ram_din;
        else          m_frd[i] = ram_din;
      end
      if (m_d[i] == 2 + w) begin
        m_busy[i] = 0;
        m_d[i]    = 0;
      end else begin
        m_d[i]++;
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      int w;
      bit st, sb, dn, eo;
      w  = wc(i);
      st = m_busy[i] && m_d[i] == 1;
      sb = m_busy[i] && m_d[i] >= 2
                     && m_d[i] <= 1 + w;
      dn = m_busy[i] && m_d[i] == 2 + w;
      eo = (st || sb) && m_we[i];
      check("m_addr", i, addr[i], m_a[i]);
      check("m_oe", i, 8'(oe[i]), 8'(eo));
      check("m_rram", i, 8'(rd[i]),
            8'(!(sb && !m_we[i])));
      check("m_wram", i, 8'(wr[i]),
            8'(!(sb && m_we[i])));
      check("m_fdone", i, 8'(fd[i]),
            8'(dn && !m_win[i]));
      check("m_ddone", i, 8'(dd[i]),
            8'(dn && m_win[i]));
      check("m_busy", i, 8'(bs[i]),
            8'(m_busy[i]));
      check("m_frd", i, frd[i], m_frd[i]);
      check("m_drd", i, drd[i], m_drd[i]);
      if (eo) check("m_dout", i, dout[i], m_wd[i]);
      if (m_fresh[i])
        check("m_dout0", i, dout[i], 8'h00);
    end
  endtask

  task automatic tick();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  typedef struct {
    int         inst;
    bit         r, fr, dr, we;
    logic [7:0] fa, da, wd, din;
    logic [7:0] ea, ed;
    bit         eo, ewr, erd, efd, edd, ebs;
    logic [7:0] efrd, edrd;
  } vec_t;

  vec_t tbl[$];

  task automatic v(int inst,
    bit r, bit fr, bit dr, bit we,
    logic [7:0] fa, logic [7:0] da,
    logic [7:0] wd, logic [7:0] din,
    logic [7:0] ea, logic [7:0] ed,
    bit eo, bit ewr, bit erd,
    bit efd, bit edd, bit ebs,
    logic [7:0] efrd, logic [7:0] edrd);
    vec_t x;
    x.inst = inst; x.r = r; x.fr = fr;
    x.dr = dr; x.we = we; x.fa = fa;
    x.da = da; x.wd = wd; x.din = din;
    x.ea = ea; x.ed = ed; x.eo = eo;
    x.ewr = ewr; x.erd = erd; x.efd = efd;
    x.edd = edd; x.ebs = ebs;
    x.efrd = efrd; x.edrd = edrd;
    tbl.push_back(x);
  endtask

  initial begin
    rst = 0; fetch_req = 0; data_req = 0;
    data_we = 0; fetch_addr = 0;
    data_addr = 0; data_wdata = 0;
    ram_din = 0;
    m_win = '{0, 0};

    // fetch read, W=1
    v(0, 0,0,0,0, 8'h00,8'h00,8'h00,8'hA5,
      8'h00,8'h00, 0,1,1,0,0,0, 8'h00,8'h00);
    v(0, 1,1,0,0, 8'h12,8'h00,8'h00,8'hA5,
      8'h12,8'h00, 0,1,1,0,0,1, 8'h00,8'h00);
    v(0, 1,1,0,0, 8'h12,8'h00,8'h00,8'hA5,
      8'h12,8'h00, 0,1,0,0,0,1, 8'h00,8'h00);
    v(0, 1,1,0,0, 8'h12,8'h00,8'h00,8'hA5,
      8'h12,8'h00, 0,1,1,1,0,1, 8'hA5,8'h00);
    v(0, 1,0,0,0, 8'h12,8'h00,8'h00,8'hA5,
      8'h12,8'h00, 0,1,1,0,0,0, 8'hA5,8'h00);
    // data write, W=3
    v(1, 0,0,0,0, 8'h00,8'h00,8'h00,8'h99,
      8'h00,8'h00, 0,1,1,0,0,0, 8'h00,8'h00);
    v(1, 1,0,1,1, 8'h00,8'h40,8'h3C,8'h99,
      8'h40,8'h3C, 1,1,1,0,0,1, 8'h00,8'h00);
    for (int k = 0; k < 3; k++)
      v(1, 1,0,1,1, 8'h00,8'h40,8'h3C,8'h99,
        8'h40,8'h3C, 1,0,1,0,0,1, 8'h00,8'h00);
    v(1, 1,0,1,1, 8'h00,8'h40,8'h3C,8'h99,
      8'h40,8'h3C, 0,1,1,0,1,1, 8'h00,8'h00);
    v(1, 1,0,0,0, 8'h00,8'h40,8'h3C,8'h99,
      8'h40,8'h3C, 0,1,1,0,0,0, 8'h00,8'h00);
    // reset in first strobe, W=3
    v(1, 0,0,0,0, 8'h00,8'h00,8'h00,8'hEE,
      8'h00,8'h00, 0,1,1,0,0,0, 8'h00,8'h00);
    v(1, 1,1,0,0, 8'h55,8'h00,8'h00,8'hEE,
      8'h55,8'h00, 0,1,1,0,0,1, 8'h00,8'h00);
    v(1, 1,1,0,0, 8'h55,8'h00,8'h00,8'hEE,
      8'h55,8'h00, 0,1,0,0,0,1, 8'h00,8'h00);
    v(1, 0,1,0,0, 8'h55,8'h00,8'h00,8'hEE,
      8'h00,8'h00, 0,1,1,0,0,0, 8'h00,8'h00);
    for (int k = 0; k < 3; k++)
      v(1, 1,0,0,0, 8'h55,8'h00,8'h00,8'hEE,
        8'h00,8'h00, 0,1,1,0,0,0, 8'h00,8'h00);
    v(1, 1,1,0,0, 8'h66,8'h00,8'h00,8'h5A,
      8'h66,8'h00, 0,1,1,0,0,1, 8'h00,8'h00);
    for (int k = 0; k < 3; k++)
      v(1, 1,1,0,0, 8'h66,8'h00,8'h00,8'h5A,
        8'h66,8'h00, 0,1,0,0,0,1, 8'h00,8'h00);
    v(1, 1,1,0,0, 8'h66,8'h00,8'h00,8'h5A,
      8'h66,8'h00, 0,1,1,1,0,1, 8'h5A,8'h00);
    v(1, 1,0,0,0, 8'h66,8'h00,8'h00,8'h5A,
      8'h66,8'h00, 0,1,1,0,0,0, 8'h5A,8'h00);
    // data_req dropped in setup, W=1
    v(0, 0,0,0,0, 8'h00,8'h00,8'h00,8'h77,
      8'h00,8'h00, 0,1,1,0,0,0, 8'h00,8'h00);
    v(0, 1,0,1,0, 8'h00,8'h21,8'h00,8'h77,
      8'h21,8'h00, 0,1,1,0,0,1, 8'h00,8'h00);
    v(0, 1,0,0,0, 8'h00,8'h21,8'h00,8'h77,
      8'h21,8'h00, 0,1,0,0,0,1, 8'h00,8'h00);
    v(0, 1,0,0,0, 8'h00,8'h21,8'h00,8'h77,
      8'h21,8'h00, 0,1,1,0,1,1, 8'h00,8'h77);
    for (int k = 0; k < 2; k++)
      v(0, 1,0,0,0, 8'h00,8'h21,8'h00,8'h77,
        8'h21,8'h00, 0,1,1,0,0,0, 8'h00,8'h77);

    foreach (tbl[k]) begin
      int i;
      i          = tbl[k].inst;
      rst        = tbl[k].r;
      fetch_req  = tbl[k].fr;
      data_req   = tbl[k].dr;
      data_we    = tbl[k].we;
      fetch_addr = tbl[k].fa;
      data_addr  = tbl[k].da;
      data_wdata = tbl[k].wd;
      ram_din    = tbl[k].din;
      tick();
      check("t_addr", i, addr[i], tbl[k].ea);
      check("t_oe", i, 8'(oe[i]), 8'(tbl[k].eo));
      check("t_wram", i, 8'(wr[i]),
            8'(tbl[k].ewr));
      check("t_rram", i, 8'(rd[i]),
            8'(tbl[k].erd));
      check("t_fdone", i, 8'(fd[i]),
            8'(tbl[k].efd));
      check("t_ddone", i, 8'(dd[i]),
            8'(tbl[k].edd));
      check("t_busy", i, 8'(bs[i]),
            8'(tbl[k].ebs));
      check("t_frd", i, frd[i], tbl[k].efrd);
      check("t_drd", i, drd[i], tbl[k].edrd);
      if (tbl[k].eo || !tbl[k].r)
        check("t_dout", i, dout[i], tbl[k].ed);
    end

    // both requests held, W=1: period of 4 cycles
    rst = 0; fetch_req = 0; data_req = 0;
    tick();
    rst = 1; fetch_req = 1; data_req = 1;
    data_we = 0; fetch_addr = 8'h0F;
    data_addr = 8'hD0;
    for (int t = 1; t <= 16; t++) begin
      int n;
      bit wn, ph;
      ram_din = 8'(8'h30 + t);
      tick();
      n  = t / 4;
      ph = (t % 4) == 3;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      wn = n[0];
`else
      wn = 0;
`endif
      check("tie_fdone", 0, 8'(fd[0]),
            8'(ph && !wn));
      check("tie_ddone", 0, 8'(dd[0]),
            8'(ph && wn));
    end

    // randomized traffic with occasional reset
    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom_range(0, 149) != 0);
      fetch_req  = ($urandom_range(0, 2) != 0);
      data_req   = ($urandom_range(0, 2) != 0);
      data_we    = 1'($urandom_range(0, 1));
      fetch_addr = 8'($urandom);
      data_addr  = 8'($urandom);
      data_wdata = 8'($urandom);
      ram_din    = 8'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Shares the single external 8-bit RAM port between two requesters: the instruction-fetch path (PC-addressed, read-only) and the data path (MAR/MDR-addressed, read/write). It grants one requester at a time and runs a fixed setup/strobe/done access sequence. The sequence drives the RAM address bus, the active-low `wram`/`rram` strobes and the tristate enable for `dataram`. It sits between the PC/MAR/MDR registers and the top-level RAM pins, replacing direct strobe decoding from the microinstruction.

## Interface
Parameters:
- `WAIT_CYC`, default 1: number of strobe-active cycles per access; legal range 1..15.

Ports (name, direction, width, meaning):
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `fetch_req` in 1: fetch read request; hold until `fetch_done`.
- `fetch_addr` in 8: fetch address (from PC).
- `fetch_rdata` out 8: last fetched byte.
- `fetch_done` out 1: one-cycle completion pulse.
- `data_req` in 1: data request; hold until `data_done`.
- `data_we` in 1: 1 = write, 0 = read.
- `data_addr` in 8: data address (from MAR).
- `data_wdata` in 8: write byte (from MDR).
- `data_rdata` out 8: last byte read by the data port.
- `data_done` out 1: one-cycle completion pulse.
- `addr_ram` out 8: RAM address.
- `ram_dout` out 8: byte driven toward `dataram`.
- `ram_oe` out 1: top level drives `dataram` from `ram_dout` when 1, else `z`.
- `ram_din` in 8: `dataram` sampled value.
- `wram` out 1: write strobe, active-low.
- `rram` out 1: read strobe, active-low.
- `busy` out 1: 1 whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, SETUP, STROBE, DONE.
- Requests are sampled only in IDLE.
- IDLE with any request → SETUP.
  - The arbiter picks the winner.
  - The winner's address, `we` and `wdata` are latched into internal registers. Fetch always latches `we` = 0.
  - `last_grant` is updated to the winner.
- SETUP (1 cycle):
  - `addr_ram` = latched address.
  - Strobes high.
  - `ram_oe` = latched `we`; `ram_dout` = latched wdata.
  - Next state: STROBE, with the wait counter loaded to `WAIT_CYC`-1.
- STROBE (`WAIT_CYC` cycles):
  - Address and write data are held.
  - `rram` = 0 for a read; `wram` = 0 for a write. The other strobe stays high.
  - `ram_oe` = latched `we`.
  - The counter decrements each cycle.
  - On the final STROBE cycle's rising edge, a read captures `ram_din` into the winner's rdata register. Next state is DONE.
- DONE (1 cycle):
  - Strobes high; `ram_oe` = 0.
  - The winner's done output is 1.
  - Next state: IDLE.
- Arbitration when both requests are high in IDLE: fixed priority or round-robin, as set under Configuration.
- Dropping `req` after grant does not abort the access. The transaction completes and done still pulses.
- A request still high in the IDLE cycle after DONE is a new transaction.
- `fetch_rdata` and `data_rdata` hold their value until the next read completion for that port. Writes leave `data_rdata` unchanged.
- Wait counter is 4 bits. `WAIT_CYC` outside 1..15 is illegal and is not checked in RTL.

## Timing
- Reset (rst = 0 at a rising edge) takes effect from any state, including mid-access. After reset:
  - State = IDLE.
  - `addr_ram` = 0, `ram_dout` = 0, `ram_oe` = 0.
  - `wram` = 1, `rram` = 1.
  - Both done outputs = 0; both rdata registers = 0.
  - `busy` = 0.
  - `last_grant` = data.
  - An interrupted access produces no done pulse.
- A request first seen high in IDLE in cycle 0 gives:
  - SETUP in cycle 1.
  - STROBE in cycles 2 .. 1+`WAIT_CYC`.
  - done = 1 in cycle 2+`WAIT_CYC`, with rdata already valid in that cycle.
- Minimum request-to-request period: 3+`WAIT_CYC` cycles.
- `addr_ram` holds its last value in IDLE and DONE.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `RAM_ARB_ROUND_ROBIN_EN` defined: on a tie, grant goes to the requester that did not win the previous grant (`last_grant` toggles). The first tie after reset goes to fetch.
- Not defined: fixed priority, fetch always wins ties. `last_grant` is still maintained but is not used.

## Test plan
- Single fetch read, `WAIT_CYC` = 1, `fetch_addr` = 0x12, `ram_din` = 0xA5 → `rram` low exactly in cycle 2, `fetch_done` in cycle 3, `fetch_rdata` = 0xA5, `wram` stays 1.
- Data write, `WAIT_CYC` = 3, `data_addr` = 0x40, `data_wdata` = 0x3C → `ram_oe` = 1 with `ram_dout` = 0x3C in cycles 1–4, `wram` low in cycles 2–4, `data_done` in cycle 5, `data_rdata` unchanged.
- Both requests held high for 4 transactions, `WAIT_CYC` = 1:
  - With the macro: grant order fetch, data, fetch, data.
  - Without the macro: fetch, fetch, fetch, fetch, and `data_done` never pulses.
- Reset asserted in the first STROBE cycle of a read → next cycle all outputs at reset values, no done pulse. A fresh request afterwards completes normally.
- `data_req` dropped in SETUP of a read with `ram_din` = 0x77 → `data_done` still pulses in cycle 3 and `data_rdata` = 0x77. No new access starts while `data_req` stays low.
